// File: rtl/ac_control_pkg.sv
// Shared types and constants for the climate controller.
// Covers the mode encoding, setpoint limits, drive scaling and datapath widths.
package ac_control_pkg;

    localparam int TEMP_W  = 7;
    localparam int SPEED_W = 3;
    localparam int HEAT_W  = 8;

    localparam logic [TEMP_W-1:0] T_MIN     = 7'd16;
    localparam logic [TEMP_W-1:0] T_MAX     = 7'd30;
    localparam logic [TEMP_W-1:0] T_DEFAULT = 7'd22;

    localparam int HEAT_STEP     = 32;
    localparam int ECO_SPEED_MAX = 3;
    localparam int ECO_HEAT_MAX  = 64;

    typedef enum logic [1:0] {
        MODE_OFF       = 2'd0,
        MODE_AUTO      = 2'd1,
        MODE_FAST_COOL = 2'd2,
        MODE_ECO       = 2'd3
    } mode_t;

    // The mode cycle wraps ECO back to OFF through natural 2-bit overflow.
    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/ac_control_if.sv
// Front-panel and actuator signals of the climate controller.
// The panel/sensor side is the master; the controller is the slave.
interface ac_control_if;
    import ac_control_pkg::*;

    logic               button_ac;
    logic               button_up;
    logic               button_down;
    logic [TEMP_W-1:0]  temperature;
    logic [SPEED_W-1:0] fan_speed;
    logic [HEAT_W-1:0]  fan_heat;

    modport master (
        output button_ac, button_up, button_down, temperature,
        input  fan_speed, fan_heat
    );

    modport slave (
        input  button_ac, button_up, button_down, temperature,
        output fan_speed, fan_heat
    );
endinterface

// File: rtl/ac_setpoint.sv
// Up/down button edge detection and the saturating user setpoint register.
// Pressing both buttons in the same cycle leaves the setpoint untouched.
module ac_setpoint
    import ac_control_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              button_up,
    input  logic              button_down,
    output logic [TEMP_W-1:0] setpoint
);

    logic [1:0]        btn;
    logic [1:0]        btn_reg;
    logic [1:0]        rise;
    logic [TEMP_W-1:0] setpoint_reg;
    logic [TEMP_W-1:0] setpoint_next;

    assign btn  = {button_down, button_up};
    assign rise = btn & ~btn_reg;

    always_comb begin
        setpoint_next = setpoint_reg;
        unique case (rise)
            2'b01:   setpoint_next = (setpoint_reg >= T_MAX) ? T_MAX : setpoint_reg + 7'd1;
            2'b10:   setpoint_next = (setpoint_reg <= T_MIN) ? T_MIN : setpoint_reg - 7'd1;
            default: setpoint_next = setpoint_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_reg      <= 2'b00;
            setpoint_reg <= T_DEFAULT;
        end else begin
            btn_reg      <= btn;
            setpoint_reg <= setpoint_next;
        end
    end

    assign setpoint = setpoint_reg;

endmodule

// File: rtl/ac_control.sv
// Climate controller top: mode FSM on button_ac, error terms against the
// setpoint, and registered fan speed / heater level per mode.
module ac_control
    import ac_control_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    ac_control_if.slave bus
);

    localparam int PROD_W = 13;

    logic [TEMP_W-1:0]  temperature_registered;
    mode_t              mode_reg;
    logic               ac_reg;

    logic [7:0]         temp_ext;
    logic [7:0]         sp_ext;
    logic [7:0]         hot;
    logic [7:0]         cold;
    logic [7:0]         err;
    logic [7:0]         eco_err;
    logic [PROD_W-1:0]  auto_heat_full;
    logic [PROD_W-1:0]  eco_heat_full;

    logic [SPEED_W-1:0] fan_speed_reg;
    logic [SPEED_W-1:0] fan_speed_next;
    logic [HEAT_W-1:0]  fan_heat_reg;
    logic [HEAT_W-1:0]  fan_heat_next;

    ac_setpoint u_setpoint (
        .clk         (clk),
        .reset       (reset),
        .button_up   (bus.button_up),
        .button_down (bus.button_down),
        .setpoint    (temperature_registered)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_reg <= MODE_OFF;
            ac_reg   <= 1'b0;
        end else begin
            ac_reg <= bus.button_ac;
            if (bus.button_ac && !ac_reg)
                mode_reg <= next_mode(mode_reg);
        end
    end

    // At most one of hot/cold is non-zero, so their sum is the absolute error.
    assign temp_ext = {1'b0, bus.temperature};
    assign sp_ext   = {1'b0, temperature_registered};
    assign hot      = (temp_ext > sp_ext) ? temp_ext - sp_ext : 8'd0;
    assign cold     = (temp_ext < sp_ext) ? sp_ext - temp_ext : 8'd0;
    assign err      = hot + cold;
    assign eco_err  = (err == 8'd0) ? 8'd0 : err - 8'd1;

    assign auto_heat_full = PROD_W'(cold)    * PROD_W'(HEAT_STEP);
    assign eco_heat_full  = PROD_W'(eco_err) * PROD_W'(HEAT_STEP);

    always_comb begin
        fan_speed_next = '0;
        fan_heat_next  = '0;
        case (mode_reg)
            MODE_AUTO: begin
                fan_speed_next = (err > 8'd7) ? 3'd7 : err[SPEED_W-1:0];
                fan_heat_next  = (auto_heat_full > PROD_W'(255)) ? 8'hFF : auto_heat_full[HEAT_W-1:0];
            end
            MODE_FAST_COOL: begin
                fan_speed_next = 3'd7;
            end
            MODE_ECO: begin
                fan_speed_next = (eco_err > 8'(ECO_SPEED_MAX)) ? SPEED_W'(ECO_SPEED_MAX)
                                                               : eco_err[SPEED_W-1:0];
                if (cold != 8'd0)
                    fan_heat_next = (eco_heat_full > PROD_W'(ECO_HEAT_MAX)) ? HEAT_W'(ECO_HEAT_MAX)
                                                                            : eco_heat_full[HEAT_W-1:0];
            end
            default: begin
                fan_speed_next = '0;
                fan_heat_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fan_speed_reg <= '0;
            fan_heat_reg  <= '0;
        end else begin
            fan_speed_reg <= fan_speed_next;
            fan_heat_reg  <= fan_heat_next;
        end
    end

    assign bus.fan_speed = fan_speed_reg;
    assign bus.fan_heat  = fan_heat_reg;

endmodule

// File: tb/tb_ac_control.sv
// Directed plus randomized bench for ac_control against an arithmetic model
// of the mode cycle, setpoint saturation and per-mode drive rules.
module tb_ac_control;

    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    ac_control_if bus ();

    ac_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_mode, m_sp;
    int m_prev_ac, m_prev_up, m_prev_dn;
    int exp_speed, exp_heat;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int model_speed(input int mode, input int sp, input int t);
        int d, a, e;
        d = t - sp;
        a = (d < 0) ? -d : d;
        e = (a > 0) ? a - 1 : 0;
        case (mode)
            1:       return imin(a, 7);
            2:       return 7;
            3:       return imin(e, 3);
            default: return 0;
        endcase
    endfunction

    function automatic int model_heat(input int mode, input int sp, input int t);
        int d, a, e;
        d = t - sp;
        a = (d < 0) ? -d : d;
        e = (a > 0) ? a - 1 : 0;
        if (d >= 0) return 0;
        case (mode)
            1:       return imin(a * 32, 255);
            3:       return imin(e * 32, 64);
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_sp = 22;
        m_prev_ac = 0; m_prev_up = 0; m_prev_dn = 0;
        exp_speed = 0; exp_heat = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".fan_speed"}, 32'(bus.fan_speed), exp_speed);
        chk({tag, ".fan_heat"},  32'(bus.fan_heat),  exp_heat);
        chk({tag, ".mode"},      32'(dut.mode_reg),  m_mode);
        chk({tag, ".setpoint"},  32'(dut.temperature_registered), m_sp);
    endtask

    // Drive inputs at the falling edge, model the rising edge, check at the next falling edge.
    task automatic step(input logic ac, input logic up, input logic dn, input int t, input string tag);
        int up_rise, dn_rise;
        bus.button_ac   = ac;
        bus.button_up   = up;
        bus.button_down = dn;
        bus.temperature = 7'(t);
        @(posedge clk);
        exp_speed = model_speed(m_mode, m_sp, t);
        exp_heat  = model_heat(m_mode, m_sp, t);
        if (ac && m_prev_ac == 0) m_mode = (m_mode + 1) % 4;
        up_rise = (up && m_prev_up == 0) ? 1 : 0;
        dn_rise = (dn && m_prev_dn == 0) ? 1 : 0;
        if (up_rise == 1 && dn_rise == 0) m_sp = imin(m_sp + 1, 30);
        if (dn_rise == 1 && up_rise == 0) m_sp = (m_sp - 1 < 16) ? 16 : m_sp - 1;
        m_prev_ac = ac; m_prev_up = up; m_prev_dn = dn;
        @(negedge clk);
        check_all(tag);
        $display("step %-10s ac=%0d up=%0d dn=%0d temp=%0d -> mode=%0d sp=%0d speed=%0d heat=%0d",
                 tag, ac, up, dn, t, dut.mode_reg, dut.temperature_registered,
                 bus.fan_speed, bus.fan_heat);
    endtask

    task automatic press(input logic ac, input logic up, input logic dn, input int t, input string tag);
        step(ac, up, dn, t, tag);
        step(1'b0, 1'b0, 1'b0, t, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.button_ac = 1'b0; bus.button_up = 1'b0; bus.button_down = 1'b0;
        bus.temperature = 7'd22;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_all("reset");

        // Mode to AUTO, setpoint to 24, warm room
        press(1, 0, 0, 22, "auto");
        chk("auto_idle.speed", 32'(bus.fan_speed), 0);
        press(0, 1, 0, 28, "up1");
        press(0, 1, 0, 28, "up2");
        chk("auto_cool.speed", 32'(bus.fan_speed), 4);
        chk("auto_cool.sp", 32'(dut.temperature_registered), 24);

        press(1, 0, 0, 28, "fast");
        chk("fast.speed", 32'(bus.fan_speed), 7);
        press(1, 0, 0, 28, "eco");
        chk("eco_cool.speed", 32'(bus.fan_speed), 3);
        chk("eco_cool.heat", 32'(bus.fan_heat), 0);
        press(1, 0, 0, 28, "off");
        chk("off.speed", 32'(bus.fan_speed), 0);

        // Heating in AUTO then ECO
        press(1, 0, 0, 18, "auto2");
        press(0, 0, 1, 18, "dn1");
        press(0, 0, 1, 18, "dn2");
        chk("auto_heat.speed", 32'(bus.fan_speed), 4);
        chk("auto_heat.heat", 32'(bus.fan_heat), 128);
        press(1, 0, 0, 18, "fast2");
        press(1, 0, 0, 18, "eco2");
        chk("eco_heat.speed", 32'(bus.fan_speed), 3);
        chk("eco_heat.heat", 32'(bus.fan_heat), 64);
        step(0, 0, 0, 21, "deadband");
        chk("deadband.speed", 32'(bus.fan_speed), 0);
        chk("deadband.heat", 32'(bus.fan_heat), 0);

        // Setpoint saturation
        repeat (10) press(0, 1, 0, 21, "sat_up");
        chk("sat_hi", 32'(dut.temperature_registered), 30);
        repeat (10) press(0, 0, 1, 21, "sat_dn");
        chk("mid", 32'(dut.temperature_registered), 20);
        repeat (10) press(0, 0, 1, 21, "sat_dn2");
        chk("sat_lo", 32'(dut.temperature_registered), 16);
        repeat (5) step(0, 1, 0, 21, "hold_up");
        step(0, 0, 0, 21, "hold_rel");
        chk("hold_once", 32'(dut.temperature_registered), 17);
        press(0, 1, 1, 21, "both");
        chk("both", 32'(dut.temperature_registered), 17);

        // Asynchronous reset mid-ECO, checked before any clock edge
        step(0, 0, 0, 12, "pre_rst");
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        check_all("rst_release");

        // Randomized operation
        for (int i = 0; i < 400; i++) begin
            int t;
            t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                            : int'($urandom_range(8, 38));
            step(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), t, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
